// File: rtl/vend_pkg.sv
// Shared types and coin valuation for the multi-slot vending controller.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package vend_pkg;

    // Coin code presented by the front end each cycle.
    typedef enum logic [1:0] {
        CNY_NULL = 2'd0,
        CNY_1    = 2'd1,
        CNY_5    = 2'd2,
        CNY_10   = 2'd3
    } money_t;

    // Controller state as reported on the status port.
    typedef logic [1:0] vend_state_t;
    localparam vend_state_t ST_OFF      = 2'd0;
    localparam vend_state_t ST_IDLE     = 2'd1;
    localparam vend_state_t ST_DISPENSE = 2'd2;
    localparam vend_state_t ST_REFUND   = 2'd3;

    // Coin values in half-CNY units; COIN_W bits hold the largest coin.
    localparam int COIN_W = 5;
    localparam logic [COIN_W-1:0] HALF_CNY_1  = 5'd2;
    localparam logic [COIN_W-1:0] HALF_CNY_5  = 5'd10;
    localparam logic [COIN_W-1:0] HALF_CNY_10 = 5'd20;

    function automatic logic [COIN_W-1:0] coin_value(input money_t c);
        logic [COIN_W-1:0] v;
        case (c)
            CNY_1:   v = HALF_CNY_1;
            CNY_5:   v = HALF_CNY_5;
            CNY_10:  v = HALF_CNY_10;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vend_stock_bank.sv
// Per-slot stock counters with decrement, refill-to-full and empty lookup.
// Latency: updates visible the cycle after dec/fill; empty lookup is combinational.
// Backpressure: none; decrement of an empty slot is ignored, refill wins over decrement.
module vend_stock_bank import vend_pkg::*; #(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_W    = 4,
    parameter int INIT_STOCK = 3,
    parameter int IDX_W      = $clog2(NUM_ITEMS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_vld,
    input  logic [IDX_W-1:0] dec_item,
    input  logic             fill_vld,
    input  logic [IDX_W-1:0] fill_item,
    input  logic [IDX_W-1:0] look_item,
    output logic             look_empty
);

    logic [STOCK_W-1:0] stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0] stock_d [NUM_ITEMS];

    // Next stock per slot: refill overrides a same-cycle decrement on that slot.
    always_comb begin
        for (int i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (dec_vld && (dec_item == IDX_W'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - STOCK_W'(1);
            end
            if (fill_vld && (fill_item == IDX_W'(i))) begin
                stock_d[i] = '1;
            end
        end
    end

    // Indices beyond NUM_ITEMS read as empty so they can never become pending.
    always_comb begin
        look_empty = 1'b1;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (look_item == IDX_W'(i)) begin
                look_empty = (stock_q[i] == '0);
            end
        end
    end

    // Stock registers, reloaded to INIT_STOCK on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(INIT_STOCK);
            end
        end else begin
            for (int i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// N-slot vending controller: bounded credit, pending selection, dispense, change; optional VEND_TIMEOUT_EN idle timer.
// Latency: price-completing coin -> drink_ready two cycles later; all pulses registered, one cycle wide.
// Backpressure: none; over-ceiling coins and coins outside IDLE are bounced via coin_reject.
module vend_ctrl_multi import vend_pkg::*; #(
    parameter int                          NUM_ITEMS   = 4,
    parameter int                          CREDIT_W    = 8,
    parameter int                          MAX_CREDIT  = 40,
    parameter int                          STOCK_W     = 4,
    parameter int                          INIT_STOCK  = 3,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_TABLE = {8'd10, 8'd6, 8'd10, 8'd5},
    parameter int                          TIMEOUT_CYC = 1000,
    localparam int                         IDX_W       = $clog2(NUM_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_btn,
    input  money_t              coin,
    input  logic                sel_valid,
    input  logic [IDX_W-1:0]    sel_item,
    input  logic                cancel_btn,
    input  logic                restock_valid,
    input  logic [IDX_W-1:0]    restock_item,
    output vend_state_t         status,
    output logic [CREDIT_W-1:0] credit,
    output logic                drink_ready,
    output logic [IDX_W-1:0]    item_out,
    output logic                refund_valid,
    output logic [CREDIT_W-1:0] refund_amount,
    output logic                coin_reject,
    output logic                sold_out
);

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                pend_vld_q, pend_vld_d;
    logic [IDX_W-1:0]    pend_item_q, pend_item_d;
    logic [IDX_W-1:0]    item_out_q, item_out_d;
    logic [CREDIT_W-1:0] refund_amount_q, refund_amount_d;
    logic                off_after_q, off_after_d;
    logic                drink_ready_q, drink_ready_d;
    logic                refund_valid_q, refund_valid_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sold_out_q, sold_out_d;

    logic                has_coin;
    logic [CREDIT_W:0]   credit_sum;
    logic                credit_over;
    logic [CREDIT_W-1:0] price;
    logic                sel_empty;
    logic                stock_dec;
    logic                stock_fill;
    logic                timeout_hit;

    assign has_coin = (coin != CNY_NULL);

    // One extra bit so the ceiling compare sees the true sum.
    assign credit_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin));
    assign credit_over = (credit_sum > (CREDIT_W+1)'(MAX_CREDIT));

    // Price of the pending slot.
    always_comb begin
        price = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (pend_item_q == IDX_W'(i)) begin
                price = PRICE_TABLE[i*CREDIT_W +: CREDIT_W];
            end
        end
    end

    vend_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_W    (STOCK_W),
        .INIT_STOCK (INIT_STOCK),
        .IDX_W      (IDX_W)
    ) u_stock (
        .clk        (clk),
        .rst        (rst),
        .dec_vld    (stock_dec),
        .dec_item   (pend_item_q),
        .fill_vld   (stock_fill),
        .fill_item  (restock_item),
        .look_item  (sel_item),
        .look_empty (sel_empty)
    );

`ifdef VEND_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMR_W-1:0] tmr_q, tmr_d;

    // Idle timer: runs while a customer has credit or a selection waiting; any activity restarts it.
    always_comb begin
        tmr_d       = tmr_q;
        timeout_hit = 1'b0;
        if (has_coin || sel_valid || cancel_btn || (state_q != ST_IDLE) ||
            !((credit_q != '0) || pend_vld_q)) begin
            tmr_d = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT_CYC - 1)) begin
            timeout_hit = 1'b1;
            tmr_d       = '0;
        end else begin
            tmr_d = tmr_q + TMR_W'(1);
        end
    end

    // Idle timer register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmr_q <= '0;
        end else begin
            tmr_q <= tmr_d;
        end
    end
`else
    // Timer compiled out: the state is held indefinitely; TIMEOUT_CYC only feeds a constant-false term.
    assign timeout_hit = (TIMEOUT_CYC < 0);
`endif

    // Main FSM: start > cancel/timeout > coin > selection within IDLE.
    always_comb begin
        state_d         = state_q;
        credit_d        = credit_q;
        pend_vld_d      = pend_vld_q;
        pend_item_d     = pend_item_q;
        item_out_d      = item_out_q;
        refund_amount_d = refund_amount_q;
        off_after_d     = off_after_q;
        drink_ready_d   = 1'b0;
        refund_valid_d  = 1'b0;
        coin_reject_d   = 1'b0;
        sold_out_d      = 1'b0;
        stock_dec       = 1'b0;
        stock_fill      = 1'b0;

        case (state_q)
            ST_OFF: begin
                coin_reject_d = has_coin;
                stock_fill    = restock_valid;
                if (start_btn) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                stock_fill = restock_valid;
                if (start_btn || cancel_btn || timeout_hit) begin
                    // Session ends: any coin this cycle bounces, selection dropped.
                    coin_reject_d = has_coin;
                    pend_vld_d    = 1'b0;
                    off_after_d   = start_btn;
                    if (credit_q != '0) begin
                        state_d         = ST_REFUND;
                        refund_valid_d  = 1'b1;
                        refund_amount_d = credit_q;
                        credit_d        = '0;
                    end else if (start_btn) begin
                        state_d = ST_OFF;
                    end
                end else begin
                    if (has_coin) begin
                        if (credit_over) begin
                            coin_reject_d = 1'b1;
                        end else begin
                            credit_d = credit_sum[CREDIT_W-1:0];
                        end
                    end
                    // Pending check uses registered credit; a selection arriving as the
                    // dispense fires is dropped so the slot cannot be re-armed at zero stock.
                    if (pend_vld_q && (credit_q >= price)) begin
                        state_d       = ST_DISPENSE;
                        drink_ready_d = 1'b1;
                        item_out_d    = pend_item_q;
                        stock_dec     = 1'b1;
                        credit_d      = credit_d - price;
                        pend_vld_d    = 1'b0;
                    end else if (sel_valid) begin
                        if (sel_empty) begin
                            sold_out_d = 1'b1;
                        end else begin
                            pend_vld_d  = 1'b1;
                            pend_item_d = sel_item;
                        end
                    end
                end
            end

            ST_DISPENSE: begin
                coin_reject_d = has_coin;
                if (credit_q != '0) begin
                    state_d         = ST_REFUND;
                    refund_valid_d  = 1'b1;
                    refund_amount_d = credit_q;
                    credit_d        = '0;
                    off_after_d     = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REFUND: begin
                coin_reject_d = has_coin;
                state_d       = off_after_q ? ST_OFF : ST_IDLE;
                off_after_d   = 1'b0;
            end

            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Controller registers; every output comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= ST_OFF;
            credit_q        <= '0;
            pend_vld_q      <= 1'b0;
            pend_item_q     <= '0;
            item_out_q      <= '0;
            refund_amount_q <= '0;
            off_after_q     <= 1'b0;
            drink_ready_q   <= 1'b0;
            refund_valid_q  <= 1'b0;
            coin_reject_q   <= 1'b0;
            sold_out_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            credit_q        <= credit_d;
            pend_vld_q      <= pend_vld_d;
            pend_item_q     <= pend_item_d;
            item_out_q      <= item_out_d;
            refund_amount_q <= refund_amount_d;
            off_after_q     <= off_after_d;
            drink_ready_q   <= drink_ready_d;
            refund_valid_q  <= refund_valid_d;
            coin_reject_q   <= coin_reject_d;
            sold_out_q      <= sold_out_d;
        end
    end

    assign status        = state_q;
    assign credit        = credit_q;
    assign drink_ready   = drink_ready_q;
    assign item_out      = item_out_q;
    assign refund_valid  = refund_valid_q;
    assign refund_amount = refund_amount_q;
    assign coin_reject   = coin_reject_q;
    assign sold_out      = sold_out_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed bench for vend_ctrl_multi: purchase, ceiling, sold-out/restock, cancel/start, reset.
// Latency: inputs driven 1ns after posedge, outputs sampled 1ns after the next posedge.
// Backpressure: n/a.
module tb_vend_ctrl_multi;
    import vend_pkg::*;

`ifdef VEND_TIMEOUT_EN
    localparam int TMO = 20;
`else
    localparam int TMO = 1000;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start_btn;
    money_t      coin;
    logic        sel_valid;
    logic [1:0]  sel_item;
    logic        cancel_btn;
    logic        restock_valid;
    logic [1:0]  restock_item;
    vend_state_t status;
    logic [7:0]  credit;
    logic        drink_ready;
    logic [1:0]  item_out;
    logic        refund_valid;
    logic [7:0]  refund_amount;
    logic        coin_reject;
    logic        sold_out;

    int checks   = 0;
    int failures = 0;

    vend_ctrl_multi #(.TIMEOUT_CYC(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_btn     (start_btn),
        .coin          (coin),
        .sel_valid     (sel_valid),
        .sel_item      (sel_item),
        .cancel_btn    (cancel_btn),
        .restock_valid (restock_valid),
        .restock_item  (restock_item),
        .status        (status),
        .credit        (credit),
        .drink_ready   (drink_ready),
        .item_out      (item_out),
        .refund_valid  (refund_valid),
        .refund_amount (refund_amount),
        .coin_reject   (coin_reject),
        .sold_out      (sold_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        start_btn     = 1'b0;
        coin          = CNY_NULL;
        sel_valid     = 1'b0;
        sel_item      = 2'd0;
        cancel_btn    = 1'b0;
        restock_valid = 1'b0;
        restock_item  = 2'd0;
    endtask

    initial begin
        logic early;
        rst = 1'b0;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_status", 32'(status), 32'(ST_OFF));
        chk("rst_credit", 32'(credit), 0);
        chk("rst_drink", 32'(drink_ready), 0);
        chk("rst_item", 32'(item_out), 0);
        chk("rst_refund_vld", 32'(refund_valid), 0);
        chk("rst_refund_amt", 32'(refund_amount), 0);
        chk("rst_reject", 32'(coin_reject), 0);
        chk("rst_soldout", 32'(sold_out), 0);
        rst = 1'b1;
        tick();

        // Coin while off bounces
        coin = CNY_1; tick(); coin = CNY_NULL;
        chk("off_reject", 32'(coin_reject), 1);
        chk("off_credit", 32'(credit), 0);
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        chk("on_status", 32'(status), 32'(ST_IDLE));

        // Slot0 (price 5): 4 credit, select, one more CNY_1 completes
        coin = CNY_1; tick(); tick(); coin = CNY_NULL;
        chk("t1_credit4", 32'(credit), 4);
        sel_valid = 1'b1; sel_item = 2'd0; tick(); sel_valid = 1'b0;
        chk("t1_wait", 32'(status), 32'(ST_IDLE));
        coin = CNY_1; tick(); coin = CNY_NULL;
        chk("t1_credit6", 32'(credit), 6);
        chk("t1_no_drink_yet", 32'(drink_ready), 0);
        tick();
        chk("t1_disp_state", 32'(status), 32'(ST_DISPENSE));
        chk("t1_drink", 32'(drink_ready), 1);
        chk("t1_item", 32'(item_out), 0);
        chk("t1_remainder", 32'(credit), 1);
        tick();
        chk("t1_refund_vld", 32'(refund_valid), 1);
        chk("t1_refund_amt", 32'(refund_amount), 1);
        chk("t1_credit0", 32'(credit), 0);
        tick();
        chk("t1_idle", 32'(status), 32'(ST_IDLE));
        chk("t1_stock0", 32'(dut.u_stock.stock_q[0]), 2);

        // Credit ceiling 40
        coin = CNY_10; tick(); tick(); coin = CNY_NULL;
        chk("t2_credit40", 32'(credit), 40);
        chk("t2_no_reject", 32'(coin_reject), 0);
        coin = CNY_1; tick(); coin = CNY_NULL;
        chk("t2_reject", 32'(coin_reject), 1);
        chk("t2_credit_held", 32'(credit), 40);
        cancel_btn = 1'b1; tick(); cancel_btn = 1'b0;
        chk("t2_refund_vld", 32'(refund_valid), 1);
        chk("t2_refund_amt", 32'(refund_amount), 40);
        tick();
        chk("t2_idle", 32'(status), 32'(ST_IDLE));

        // Slot3 (price 10) three times, then sold out
        for (int n = 0; n < 3; n++) begin
            coin = CNY_5; tick(); tick(); coin = CNY_NULL;
            sel_valid = 1'b1; sel_item = 2'd3; tick(); sel_valid = 1'b0;
            tick();
            chk("t3_drink", 32'(drink_ready), 1);
            chk("t3_item", 32'(item_out), 3);
            tick();
            chk("t3_refund_amt", 32'(refund_amount), 10);
            tick();
        end
        sel_valid = 1'b1; sel_item = 2'd3; tick(); sel_valid = 1'b0;
        chk("t3_sold_out", 32'(sold_out), 1);
        coin = CNY_10; tick(); coin = CNY_NULL;
        chk("t3_sold_out_pulse", 32'(sold_out), 0);
        tick(); tick();
        chk("t3_no_pending", 32'(status), 32'(ST_IDLE));
        chk("t3_credit20", 32'(credit), 20);
        restock_valid = 1'b1; restock_item = 2'd3; tick(); restock_valid = 1'b0;
        sel_valid = 1'b1; sel_item = 2'd3; tick(); sel_valid = 1'b0;
        tick();
        chk("t3_restock_drink", 32'(drink_ready), 1);
        chk("t3_restock_item", 32'(item_out), 3);
        tick();
        chk("t3_restock_refund", 32'(refund_amount), 10);
        tick();
        chk("t3_stock3", 32'(dut.u_stock.stock_q[3]), 14);

        // Coin with cancel bounces; start with credit refunds then powers off
        coin = CNY_1; cancel_btn = 1'b1; tick(); coin = CNY_NULL; cancel_btn = 1'b0;
        chk("t4_reject", 32'(coin_reject), 1);
        chk("t4_credit0", 32'(credit), 0);
        chk("t4_no_refund", 32'(refund_valid), 0);
        chk("t4_idle", 32'(status), 32'(ST_IDLE));
        coin = CNY_1; tick(); tick(); coin = CNY_NULL;
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        chk("t4_refund_state", 32'(status), 32'(ST_REFUND));
        chk("t4_refund_amt", 32'(refund_amount), 4);
        tick();
        chk("t4_off", 32'(status), 32'(ST_OFF));

        // Reset during dispense of slot1
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        coin = CNY_5; sel_valid = 1'b1; sel_item = 2'd1; tick();
        coin = CNY_NULL; sel_valid = 1'b0;
        tick();
        chk("t5_disp_item", 32'(item_out), 1);
        #1 rst = 1'b0;
        #1;
        chk("t5_status", 32'(status), 32'(ST_OFF));
        chk("t5_credit", 32'(credit), 0);
        chk("t5_drink", 32'(drink_ready), 0);
        chk("t5_item", 32'(item_out), 0);
        chk("t5_refund_amt", 32'(refund_amount), 0);
        chk("t5_stock0", 32'(dut.u_stock.stock_q[0]), 3);
        chk("t5_stock1", 32'(dut.u_stock.stock_q[1]), 3);
        chk("t5_stock3", 32'(dut.u_stock.stock_q[3]), 3);
        #1 rst = 1'b1;
        tick();
        chk("t5_after_release", 32'(status), 32'(ST_OFF));

`ifdef VEND_TIMEOUT_EN
        // Inactivity timeout acts as cancel
        start_btn = 1'b1; tick(); start_btn = 1'b0;
        coin = CNY_1; tick(); coin = CNY_NULL;
        early = 1'b0;
        for (int n = 0; n < TMO - 1; n++) begin
            tick();
            early = early | refund_valid;
        end
        chk("t6_no_early_refund", 32'(early), 0);
        tick();
        chk("t6_refund_vld", 32'(refund_valid), 1);
        chk("t6_refund_amt", 32'(refund_amount), 2);
`else
        early = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
